varredura_botoes: RTL and testbench
===================================

# varredura_botoes

Scans a 2×4 push-button keypad and converts it into debounced, one-cycle press pulses on an 8-bit bus that plugs straight into the LED-matrix controller's `botoes` input. It drives the keypad rows the same way the matrix controller drives its LED rows: one line active at a time, time-multiplexed. It reads the columns back through a synchronizer and applies per-key debounce across successive scans. It sits between the board pins and the LED-matrix controller in the top level.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 4: cycles a row is driven before it is sampled. Must be ≥ 3 to cover the 2-flop synchronizer latency.
- `DEBOUNCE_SCANS`, default 3: number of consecutive full scans a key must disagree with its debounced state before the change is accepted. Range 1–15.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Asynchronous, active-high; clock is `clk`.
- `enable`  in  1  scanning allowed. When low, the block idles.
- `col_in`  in  4  keypad column returns. Active-low; pulled up off-chip.
- `row_out`  out  2  keypad row drive. Active-low; at most one bit low at a time.
- `pulso`  out  8  one-clock press pulses. Key k = row*4 + col.
- `estado`  out  8  debounced key levels. 1 = pressed.

## Operation
- `col_in` passes through a 2-flop synchronizer. All sampling uses the synchronized value `col_s`.
- FSM states: IDLE, DRIVE_R0, SAMPLE_R0, DRIVE_R1, SAMPLE_R1, UPDATE.
- IDLE:
  - `row_out` = 2'b11.
  - Go to DRIVE_R0 when `enable` = 1.
- DRIVE_Rn:
  - `row_out` = row n low (R0 → 2'b10, R1 → 2'b01).
  - A dwell counter runs for SETTLE_CYCLES cycles, then moves to SAMPLE_Rn.
- SAMPLE_Rn:
  - Same `row_out` as DRIVE_Rn; lasts 1 cycle.
  - Captures `raw[4n+3:4n]` = `~col_s`.
  - Next state: SAMPLE_R0 → DRIVE_R1; SAMPLE_R1 → UPDATE.
- UPDATE:
  - `row_out` = 2'b11; lasts 1 cycle.
  - Per-key debounce is evaluated (below).
  - Next state: DRIVE_R0 if `enable` = 1, else IDLE.
- Per-key debounce, evaluated for each k in UPDATE, using a 4-bit counter `cnt[k]`:
  - If `raw[k] == estado[k]`: `cnt[k]` ← 0.
  - Else if `cnt[k] == DEBOUNCE_SCANS-1`: `estado[k]` ← `raw[k]`, `cnt[k]` ← 0, `pulso[k]` ← `raw[k]`. A pulse is generated on press only, never on release.
  - Else: `cnt[k]` ← `cnt[k]` + 1.
- Keys are independent. Any number of `pulso` bits may assert in the same cycle.
- Ghosting is not handled; the keypad has per-key diodes.
- `enable` low:
  - Taking effect at the next state boundary, the FSM goes to IDLE. It does not abort mid-row.
  - In IDLE, all `cnt` are cleared.
  - `estado` holds its value; `pulso` = 0.
- `pulso` is registered. It is 0 in every cycle except the one following UPDATE.

## Timing
- Reset values (asynchronous):
  - `row_out` = 2'b11, `pulso` = 8'h00, `estado` = 8'h00.
  - FSM in IDLE; all `cnt` = 0; `raw` = 0; synchronizer flops = 4'b1111.
- Scan period P = 2·(SETTLE_CYCLES+1) + 1 cycles. With defaults, P = 11.
- `pulso[k]` is high for exactly one cycle: the cycle after the clock edge that ends UPDATE. `estado[k]` rises on that same edge.
- Press latency: a key held steadily before a scan starts is accepted at the DEBOUNCE_SCANS-th UPDATE. With defaults, that is 33 cycles after the first DRIVE_R0 of that scan.
- Release latency is the same; no pulse is generated.
- Boundary behaviour:
  - Bounce: any scan where a key agrees with `estado` clears that key's counter. A key toggling every scan never changes `estado`.
  - A held key produces no repeat pulses.
  - Reset mid-scan: everything returns to reset values immediately. A key still held after `rst` falls must pass a full debounce again, then pulses once.
  - Raising `enable` from IDLE: DRIVE_R0 begins on the next cycle.
  - Row-drive overlap: `row_out` never shows 2'b00, including across the SAMPLE_R0 → DRIVE_R1 transition.

## Test plan
Defaults for all scenarios: SETTLE_CYCLES = 4, DEBOUNCE_SCANS = 3, P = 11.
- Reset: assert `rst` with `enable` = 1 and `col_in` = 4'hF → `row_out` = 2'b11, `pulso` = 0, `estado` = 0. `row_out` then cycles 10 → 01 → 11 with period 11, and 00 never appears.
- Single key: hold key 5 (`col_in` = 4'b1101 whenever `row_out` = 2'b01) → exactly one cycle with `pulso` = 8'h20 at the 3rd UPDATE, then `estado` = 8'h20. Holding for 20 more scans gives no further pulse. On release, `estado` = 8'h00 after 3 scans, with no pulse.
- Bounce: key 0 alternates pressed/released every scan for 10 scans → `pulso` = 0 throughout, `estado[0]` = 0.
- Simultaneous keys: keys 2 and 7 pressed together → a single cycle with `pulso` = 8'h84, then `estado` = 8'h84.
- Reset mid-operation: key 3 held, `rst` pulsed during the 2nd scan's DRIVE_R1 → `estado` = 0 immediately. After `rst` falls, `pulso` = 8'h08 once, 3 full scans later.
- Enable gating: key 1 held, `enable` dropped after the 1st scan → `row_out` settles at 2'b11 and stays there. After re-enable, the counter has restarted: `pulso` = 8'h02 at the 3rd subsequent UPDATE.

Source files
------------

// File: rtl/varredura_botoes.sv
// Scans a 2x4 keypad one row at a time, debounces each key over whole scans and emits one-clock press pulses.
// Scan period 2*(SETTLE_CYCLES+1)+1 cycles; a press is accepted at the DEBOUNCE_SCANS-th UPDATE; no backpressure.
module varredura_botoes #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] col_in,
    output logic [1:0] row_out,
    output logic [7:0] pulso,
    output logic [7:0] estado
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_DRIVE_R0  = 3'd1;
    localparam logic [2:0] S_SAMPLE_R0 = 3'd2;
    localparam logic [2:0] S_DRIVE_R1  = 3'd3;
    localparam logic [2:0] S_SAMPLE_R1 = 3'd4;
    localparam logic [2:0] S_UPDATE    = 3'd5;

    localparam int            DW         = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYCLES - 1);
    localparam logic [3:0]    CNT_LAST   = 4'(DEBOUNCE_SCANS - 1);

    logic [3:0]    r_sync1;
    logic [3:0]    r_col_s;
    logic [2:0]    r_state;
    logic [DW-1:0] r_dwell;
    logic [7:0]    r_raw;
    logic [3:0]    r_cnt [0:7];
    logic [7:0]    r_estado;
    logic [7:0]    r_pulso;
    logic          w_dwell_done;
    logic          w_driving;

    assign w_dwell_done = (r_dwell == DWELL_LAST);
    assign w_driving    = (r_state == S_DRIVE_R0) || (r_state == S_DRIVE_R1);
    assign pulso        = r_pulso;
    assign estado       = r_estado;

    // Idle value of the synchronizer is "no column pulled low".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 4'b1111;
            r_col_s <= 4'b1111;
        end else begin
            r_sync1 <= col_in;
            r_col_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_dwell <= '0;
        end else begin
            if (w_driving && !w_dwell_done) begin
                r_dwell <= r_dwell + 1'b1;
            end else begin
                r_dwell <= '0;
            end
            case (r_state)
                S_IDLE:      if (enable) r_state <= S_DRIVE_R0;
                S_DRIVE_R0:  if (w_dwell_done) r_state <= S_SAMPLE_R0;
                S_SAMPLE_R0: r_state <= S_DRIVE_R1;
                S_DRIVE_R1:  if (w_dwell_done) r_state <= S_SAMPLE_R1;
                S_SAMPLE_R1: r_state <= S_UPDATE;
                S_UPDATE:    r_state <= enable ? S_DRIVE_R0 : S_IDLE;
                default:     r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        row_out = 2'b11;
        case (r_state)
            S_DRIVE_R0, S_SAMPLE_R0: row_out = 2'b10;
            S_DRIVE_R1, S_SAMPLE_R1: row_out = 2'b01;
            default:                 row_out = 2'b11;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_raw <= '0;
        end else if (r_state == S_SAMPLE_R0) begin
            r_raw[3:0] <= ~r_col_s;
        end else if (r_state == S_SAMPLE_R1) begin
            r_raw[7:4] <= ~r_col_s;
        end
    end

    // A key must disagree with its debounced level for DEBOUNCE_SCANS consecutive scans.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= '0;
            r_pulso  <= '0;
            for (int k = 0; k < 8; k++) r_cnt[k] <= '0;
        end else begin
            r_pulso <= '0;
            if (r_state == S_IDLE) begin
                for (int k = 0; k < 8; k++) r_cnt[k] <= '0;
            end else if (r_state == S_UPDATE) begin
                for (int k = 0; k < 8; k++) begin
                    if (r_raw[k] == r_estado[k]) begin
                        r_cnt[k] <= '0;
                    end else if (r_cnt[k] == CNT_LAST) begin
                        r_estado[k] <= r_raw[k];
                        r_pulso[k]  <= r_raw[k];
                        r_cnt[k]    <= '0;
                    end else begin
                        r_cnt[k] <= r_cnt[k] + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_varredura_botoes.sv
// Bench for varredura_botoes: a keypad model answers the row drive; expected pulses go through a scoreboard queue.
module tb_varredura_botoes;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [3:0] col_in;
    logic [1:0] row_out;
    logic [7:0] pulso;
    logic [7:0] estado;
    logic [7:0] keys;

    typedef struct {
        logic [7:0] p;
        logic [7:0] e;
        int         due;
    } exp_t;

    exp_t       q[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         n_upd = 0;
    logic [1:0] prev_row = 2'b11;

    always #5 clk = ~clk;

    varredura_botoes #(.SETTLE_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
        .clk(clk), .rst(rst), .enable(enable), .col_in(col_in),
        .row_out(row_out), .pulso(pulso), .estado(estado)
    );

    // Keypad with per-key diodes: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!row_out[0] && keys[c])     col_in[c] = 1'b0;
            if (!row_out[1] && keys[4 + c]) col_in[c] = 1'b0;
        end
    end

    // Counts completed UPDATE cycles (row 01 followed by 11 while out of reset).
    always @(posedge clk) begin
        prev_row <= row_out;
        if (!rst && row_out == 2'b11 && prev_row == 2'b01) n_upd <= n_upd + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            check("row_overlap", {31'd0, row_out == 2'b00}, 32'd0);
            if (pulso != 8'h00) begin
                if (q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL unexpected_pulse: got %0h expected none", pulso);
                end else begin
                    e = q.pop_front();
                    check("pulse_value", {24'd0, pulso}, {24'd0, e.p});
                    check("pulse_scan", n_upd, e.due);
                    check("pulse_estado", {24'd0, estado}, {24'd0, e.e});
                end
            end
        end
    end

    task automatic wait_upd(input int n);
        int target;
        int budget;
        target = n_upd + n;
        budget = n * 11 + 50;
        while (n_upd < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (n_upd < target) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_update: got %0d updates expected %0d", n_upd, target);
        end
    endtask

    task automatic wait_row1();
        int b;
        b = 0;
        while (row_out != 2'b01 && b < 20) begin
            @(negedge clk);
            b++;
        end
        check("reach_row1", {30'd0, row_out}, 32'd1);
    endtask

    initial begin
        logic [1:0] exp_row;
        rst    = 1'b1;
        enable = 1'b1;
        keys   = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_row", {30'd0, row_out}, 32'h3);
        check("rst_pulso", {24'd0, pulso}, 32'h0);
        check("rst_estado", {24'd0, estado}, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            exp_row = ((i % 11) < 5) ? 2'b10 : (((i % 11) < 10) ? 2'b01 : 2'b11);
            check("row_sequence", {30'd0, row_out}, {30'd0, exp_row});
        end

        // Single key 5, held, then released.
        wait_upd(1);
        keys = 8'h20;
        q.push_back('{p: 8'h20, e: 8'h20, due: n_upd + 3});
        wait_upd(3);
        check("key5_estado", {24'd0, estado}, 32'h20);
        wait_upd(20);
        check("key5_held", {24'd0, estado}, 32'h20);
        keys = 8'h00;
        wait_upd(2);
        check("key5_rel_2scans", {24'd0, estado}, 32'h20);
        wait_upd(1);
        check("key5_rel_3scans", {24'd0, estado}, 32'h0);

        // Key 0 bouncing every scan.
        for (int s = 0; s < 10; s++) begin
            keys = (s % 2 == 0) ? 8'h01 : 8'h00;
            wait_upd(1);
            check("bounce_estado", {24'd0, estado}, 32'h0);
        end
        keys = 8'h00;
        wait_upd(1);

        // Keys 2 and 7 together.
        keys = 8'h84;
        q.push_back('{p: 8'h84, e: 8'h84, due: n_upd + 3});
        wait_upd(3);
        check("simul_estado", {24'd0, estado}, 32'h84);
        keys = 8'h00;
        wait_upd(4);
        check("simul_release", {24'd0, estado}, 32'h0);

        // Key 3 held, reset during the second scan's row-1 drive.
        keys = 8'h08;
        wait_upd(1);
        wait_row1();
        rst = 1'b1;
        #1;
        check("midrst_estado", {24'd0, estado}, 32'h0);
        check("midrst_row", {30'd0, row_out}, 32'h3);
        check("midrst_pulso", {24'd0, pulso}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.push_back('{p: 8'h08, e: 8'h08, due: n_upd + 3});
        wait_upd(3);
        check("midrst_after", {24'd0, estado}, 32'h08);
        keys = 8'h00;
        wait_upd(4);
        check("midrst_release", {24'd0, estado}, 32'h0);

        // Key 1 held, enable dropped during the first scan.
        keys = 8'h02;
        wait_row1();
        enable = 1'b0;
        wait_upd(1);
        for (int i = 0; i < 30; i++) begin
            check("idle_row", {30'd0, row_out}, 32'h3);
            @(negedge clk);
        end
        check("idle_estado", {24'd0, estado}, 32'h0);
        enable = 1'b1;
        q.push_back('{p: 8'h02, e: 8'h02, due: n_upd + 3});
        @(negedge clk);
        check("enable_to_drive", {30'd0, row_out}, 32'h2);
        wait_upd(3);
        check("enable_estado", {24'd0, estado}, 32'h02);

        repeat (5) @(negedge clk);
        check("pending_pulses", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
